// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: reset PC, nop encoding and
// the fetch sequencer state encoding.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, single-word hold
// buffer for D-stage stalls, and delay-slot-aware redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0]  pc_F;
    logic [31:0]  ibuf;
    logic         redir_pend;
    logic [31:0]  redir_pc;
    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0]  npc;
    logic         advance;
    logic         load_ibuf;

    // A redirect seen this cycle wins over one parked earlier; the parked one
    // only exists because the delay slot had not been consumed yet.
    always_comb begin
        npc = redirect   ? redirect_pc :
              redir_pend ? redir_pc    :
                           pc_F + 32'd4;
    end

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        load_ibuf = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc_F;
        out_pc    = pc_F;
        out_instr = NOP;

        case (state)
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_F;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    out_instr = imem_rdata;
                    if (!stall) begin
                        advance   = 1'b1;
                        imem_req  = 1'b1;
                        imem_addr = npc;
                    end else begin
                        load_ibuf = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                out_instr = ibuf;
                if (!stall) begin
                    advance   = 1'b1;
                    imem_req  = 1'b1;
                    imem_addr = npc;
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // Outputs are quiet for the whole reset pulse, not just after the edge.
        if (reset) begin
            imem_req  = 1'b0;
            out_instr = NOP;
            out_pc    = PC_RESET;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc_F       <= PC_RESET;
            ibuf       <= NOP;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                pc_F <= npc;
            end
            if (load_ibuf) begin
                ibuf <= imem_rdata;
            end
            if (advance) begin
                redir_pend <= 1'b0;
            end else if (redirect) begin
                redir_pend <= 1'b1;
                redir_pc   <= redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: bench-side memory with random
// latency, program-order model of fetch addresses, and an output monitor.
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    initial forever #5 clk = ~clk;

    // stimulus knobs (owned by the main process)
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned stall_pct = 0;
    int unsigned redir_pct = 0;
    logic        stale_enable = 1'b0;

    // driver -> monitor
    logic        presented = 1'b0;
    logic        consumed = 1'b0;
    logic        mem_busy = 1'b0;
    logic        exp_push_valid = 1'b0;
    logic [31:0] exp_push_addr = '0;

    // monitor -> driver
    logic        req_seen = 1'b0;
    logic [31:0] req_addr = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] addr_q[$];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_word[$];

    // Nonzero for every address so a real word never looks like a bubble.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b01} ^ 32'hC3A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: memory responder, stall/redirect stimulus and program-order model.
    initial begin
        int unsigned mem_cnt;
        logic [31:0] mem_addr;
        logic        word_avail;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] model_pc;
        logic        first_after_reset;
        logic [31:0] r;
        mem_cnt = 0; mem_addr = '0; word_avail = 1'b0; rv = 1'b0; rt = '0;
        model_pc = PC_RESET; first_after_reset = 1'b1;
        forever begin
            @(negedge clk);
            presented      = 1'b0;
            consumed       = 1'b0;
            exp_push_valid = 1'b0;
            imem_rvalid    = 1'b0;
            imem_rdata     = '0;
            if (reset) begin
                stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
                mem_busy = 1'b0; word_avail = 1'b0; rv = 1'b0;
                model_pc = PC_RESET; first_after_reset = 1'b1;
            end else begin
                if (first_after_reset) begin
                    exp_push_valid = 1'b1;
                    exp_push_addr  = PC_RESET;
                    model_pc       = PC_RESET;
                end
                if (req_seen) begin
                    mem_busy = 1'b1;
                    mem_addr = req_addr;
                    mem_cnt  = $urandom_range(lat_max, lat_min);
                end
                if (mem_busy) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_addr);
                        mem_busy    = 1'b0;
                        word_avail  = 1'b1;
                    end
                end
                if (first_after_reset && stale_enable) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hDEAD_BEEF;
                end
                first_after_reset = 1'b0;

                stall    = ($urandom_range(99, 0) < stall_pct);
                redirect = ($urandom_range(99, 0) < redir_pct);
                r = $urandom;
                redirect_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);

                presented = word_avail;
                if (word_avail && !stall) begin
                    consumed   = 1'b1;
                    word_avail = 1'b0;
                    model_pc   = redirect ? redirect_pc : (rv ? rt : model_pc + 32'd4);
                    rv         = 1'b0;
                    exp_push_valid = 1'b1;
                    exp_push_addr  = model_pc;
                end else if (redirect) begin
                    rv = 1'b1;
                    rt = redirect_pc;
                end
            end
        end
    end

    // Monitor: owns the scoreboard queues, compares DUT outputs mid-cycle.
    initial begin
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                check("reset_imem_req", {31'b0, imem_req}, 32'h0);
                check("reset_out_instr", out_instr, 32'h0);
                check("reset_out_pc", out_pc, PC_RESET);
                req_seen = 1'b0;
                addr_q.delete(); dq_pc.delete(); dq_word.delete();
            end else begin
                if (exp_push_valid) addr_q.push_back(exp_push_addr);
                if (imem_req) begin
                    check("one_outstanding", {31'b0, mem_busy}, 32'h0);
                    n_checks++;
                    if (addr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_req: got addr %h, expected no request at %0t", imem_addr, $time);
                    end else begin
                        ea = addr_q.pop_front();
                        check("req_addr", imem_addr, ea);
                        dq_pc.push_back(ea);
                        dq_word.push_back(mem_word(ea));
                    end
                    req_seen = 1'b1;
                    req_addr = imem_addr;
                end else begin
                    req_seen = 1'b0;
                    n_checks++;
                    if (addr_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL missing_req: got no request, expected addr %h at %0t", addr_q[0], $time);
                        addr_q.delete();
                    end
                end
                if (presented) begin
                    n_checks++;
                    if (dq_word.size() == 0) begin
                        n_fail++;
                        $display("FAIL deliver_empty: got instr %h, expected no word in flight at %0t", out_instr, $time);
                    end else begin
                        check("out_instr", out_instr, dq_word[0]);
                        check("out_pc", out_pc, dq_pc[0]);
                        if (consumed) begin
                            void'(dq_word.pop_front());
                            void'(dq_pc.pop_front());
                        end
                    end
                end else begin
                    check("bubble", out_instr, 32'h0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);              // latency 1, no stalls
        #1 lat_min = 3; lat_max = 3;
        repeat (15) @(posedge clk);              // latency 3
        #1 lat_min = 1; lat_max = 1; stall_pct = 50;
        repeat (30) @(posedge clk);              // stall/hold
        #1 lat_min = 1; lat_max = 2; stall_pct = 0; redir_pct = 30;
        repeat (60) @(posedge clk);              // redirects, mostly same-cycle
        #1 lat_min = 1; lat_max = 4; stall_pct = 30; redir_pct = 15;
        repeat (1500) @(posedge clk);            // mixed random
        #1 lat_min = 3; lat_max = 3; stall_pct = 0; redir_pct = 0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1; stale_enable = 1'b1;    // reset mid-flight
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 stale_enable = 1'b0; lat_min = 1; lat_max = 4; stall_pct = 30; redir_pct = 15;
        repeat (500) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
